// File: rtl/bsg_async_fifo_wptr_ctrl.sv
// bsg_async_fifo_wptr_ctrl: write-side pointer, Gray launch register, full/occupancy/error for an async FIFO
module bsg_async_fifo_wptr_ctrl #(
    parameter int lg_size_p = 4,
    localparam int pw = lg_size_p + 1
) (
    input  logic                 iclk_i,
    input  logic                 iclk_reset_i,
    input  logic                 v_i,
    output logic                 ready_o,
    output logic                 w_en_o,
    output logic [lg_size_p-1:0] w_addr_o,
    output logic [pw-1:0]        w_ptr_gray_o,
    input  logic [pw-1:0]        r_ptr_gray_i,
    output logic                 full_o,
    output logic [pw-1:0]        occupancy_o,
    output logic                 err_o
);
    localparam logic [pw-1:0] depth_lp = {1'b1, {lg_size_p{1'b0}}};
    logic [pw-1:0] w_ptr_bin_q, w_ptr_bin_d, w_ptr_gray_q, w_ptr_gray_d;
    logic [pw-1:0] b_next, r_bin, r_full_cmp;
    logic          err_q, err_d;
    // Full when the read pointer is one lap behind: top two Gray bits inverted, rest equal.
    generate
        if (lg_size_p == 1) begin : g_small
            assign r_full_cmp = ~r_ptr_gray_i;
        end else begin : g_wide
            assign r_full_cmp = {~r_ptr_gray_i[pw-1:pw-2], r_ptr_gray_i[pw-3:0]};
        end
    endgenerate
    always_comb begin
        r_bin = '0;
        for (int i = 0; i < pw; i++) r_bin[i] = ^(r_ptr_gray_i >> i);
    end
    assign full_o       = (w_ptr_gray_q == r_full_cmp);
    assign ready_o      = ~full_o & ~iclk_reset_i;
    assign w_en_o       = v_i & ready_o;
    assign w_addr_o     = w_ptr_bin_q[lg_size_p-1:0];
    assign w_ptr_gray_o = w_ptr_gray_q;
    assign occupancy_o  = w_ptr_bin_q - r_bin;
    assign err_o        = err_q;
    assign b_next       = w_ptr_bin_q + 1'b1;
    always_comb begin
        w_ptr_bin_d  = w_en_o ? b_next : w_ptr_bin_q;
        w_ptr_gray_d = w_en_o ? (b_next ^ (b_next >> 1)) : w_ptr_gray_q;
        err_d        = err_q | (occupancy_o > depth_lp);
    end
    always_ff @(posedge iclk_i) begin
        if (iclk_reset_i) begin
            w_ptr_bin_q  <= '0;
            w_ptr_gray_q <= '0;
            err_q        <= 1'b0;
        end else begin
            w_ptr_bin_q  <= w_ptr_bin_d;
            w_ptr_gray_q <= w_ptr_gray_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_bsg_async_fifo_wptr_ctrl.sv
// tb_bsg_async_fifo_wptr_ctrl: directed checks of the write pointer controller at lg_size_p=2
module tb_bsg_async_fifo_wptr_ctrl;
    logic       clk = 1'b0;
    logic       rst, v;
    logic       ready, w_en, full, err;
    logic [1:0] addr;
    logic [2:0] gray, r_gray, occ, prev;
    int         tests = 0, fails = 0, wb;
    logic [2:0] gtbl [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    logic [2:0] fill_seq [4] = '{3'b001, 3'b011, 3'b010, 3'b110};

    bsg_async_fifo_wptr_ctrl #(.lg_size_p(2)) dut (
        .iclk_i(clk), .iclk_reset_i(rst), .v_i(v), .ready_o(ready), .w_en_o(w_en),
        .w_addr_o(addr), .w_ptr_gray_o(gray), .r_ptr_gray_i(r_gray), .full_o(full),
        .occupancy_o(occ), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; v = 1'b1; r_gray = 3'b000;
        tick; tick;
        #1;
        check("rst_w_en", w_en, 0);
        check("rst_ready", ready, 0);
        check("rst_gray", gray, 0);
        check("rst_occ", occ, 0);
        check("rst_err", err, 0);
        check("rst_full", full, 0);
        check("rst_addr", addr, 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fill_w_en", w_en, 1);
            check("fill_addr", addr, k);
            tick;
            check("fill_gray", gray, fill_seq[k]);
        end
        #1;
        check("full_flag", full, 1);
        check("full_ready", ready, 0);
        check("full_w_en", w_en, 0);
        check("full_occ", occ, 4);
        tick;
        check("full_hold_gray", gray, 3'b110);
        check("full_hold_occ", occ, 4);
        r_gray = 3'b001;
        #1;
        check("drain_full", full, 0);
        check("drain_ready", ready, 1);
        check("drain_occ", occ, 3);
        check("drain_addr", addr, 0);
        tick;
        check("drain_gray", gray, 3'b111);
        check("drain_err", err, 0);
        wb = 5;
        for (int i = 0; i < 16; i++) begin
            r_gray = gtbl[(wb + 7) % 8];
            prev = gray;
            #1;
            check("wrap_full", full, 0);
            check("wrap_occ", occ, 1);
            check("wrap_w_en", w_en, 1);
            tick;
            wb++;
            check("wrap_gray", gray, gtbl[wb % 8]);
            check("wrap_onebit", $countones(gray ^ prev), 1);
        end
        rst = 1'b1; v = 1'b0;
        tick;
        rst = 1'b0; r_gray = 3'b010;
        #1;
        check("err_occ", occ, 5);
        check("err_not_yet", err, 0);
        tick;
        check("err_set", err, 1);
        r_gray = 3'b000;
        tick;
        #1;
        check("err_sticky", err, 1);
        check("err_occ_zero", occ, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check("err_cleared", err, 0);
        v = 1'b1;
        tick; tick; tick;
        check("mid_gray3", gray, 3'b010);
        rst = 1'b1;
        #1;
        check("mid_rst_w_en", w_en, 0);
        check("mid_rst_ready", ready, 0);
        tick;
        rst = 1'b0;
        check("mid_gray0", gray, 3'b000);
        #1;
        check("mid_w_en", w_en, 1);
        check("mid_addr", addr, 0);
        tick;
        check("mid_gray1", gray, 3'b001);
        v = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bsg_async_fifo_wptr_ctrl.md
Name: bsg_async_fifo_wptr_ctrl

Overview:
Write-side pointer controller for an async FIFO, clocked in the launch (iclk) domain. It owns the binary write pointer and drives the write enable and address for the FIFO storage. It registers a Gray-coded copy of the pointer, which feeds the launch/sync/sync synchronizer's iclk_data_i. It takes the read pointer back from the opposite synchronizer's output and uses it to compute full and occupancy.

Parameters:
lg_size_p, 4, log2 of FIFO depth; depth = 2^lg_size_p; pointer width pw = lg_size_p+1

Ports:
iclk_i  input  1  write-domain clock; all state updates on posedge
iclk_reset_i  input  1  synchronous, active-high reset
v_i  input  1  write request valid
ready_o  output  1  block can accept a write this cycle
w_en_o  output  1  storage write enable; equals v_i & ready_o
w_addr_o  output  lg_size_p  storage write address
w_ptr_gray_o  output  pw  registered Gray write pointer; drives the synchronizer
r_ptr_gray_i  input  pw  read pointer in Gray code, already synchronized into iclk
full_o  output  1  FIFO full
occupancy_o  output  pw  entries written but not yet seen as read, range 0..2^lg_size_p
err_o  output  1  sticky protocol error

Behaviour:
- State registers: w_ptr_bin_r[pw], w_ptr_gray_r[pw], err_r. All three clear to 0 on the posedge where iclk_reset_i=1.
- Reset values after reset: w_addr_o=0, w_ptr_gray_o=0, full_o=0 (with r_ptr_gray_i=0), occupancy_o=0, err_o=0.
- While iclk_reset_i=1: ready_o=0 and w_en_o=0, whatever v_i is. A reset mid-stream discards any in-flight increment; pointers return to 0 on that edge.
- Full is combinational: full_o = (w_ptr_gray_r == {~r_ptr_gray_i[pw-1:pw-2], r_ptr_gray_i[pw-3:0]}).
- For lg_size_p=1, full_o = (w_ptr_gray_r == ~r_ptr_gray_i).
- ready_o = ~full_o & ~iclk_reset_i.
- Handshake: a write is accepted when v_i & ready_o. In that cycle w_en_o=1 and w_addr_o = w_ptr_bin_r[lg_size_p-1:0].
- If v_i=1 while full, nothing is accepted and the pointers hold. This is not an error; the producer retries.
- On an accepted write at posedge:
  - b_next = w_ptr_bin_r + 1, wrapping modulo 2^pw.
  - w_ptr_bin_r <= b_next.
  - w_ptr_gray_r <= b_next ^ (b_next >> 1).
- w_ptr_gray_o comes directly from a flop, with no combinational logic after it. This is required for a glitch-free CDC launch.
- Across any single clock edge, at most one bit of w_ptr_gray_o changes.
- Latency: the pointer update is visible on w_ptr_gray_o one cycle after acceptance.
- Occupancy is combinational:
  - r_bin = Gray-to-binary of r_ptr_gray_i, computed as prefix XOR from the MSB down.
  - occupancy_o = (w_ptr_bin_r - r_bin) mod 2^pw.
- Full, occupancy and the error check all compare against the registered pointer, never the pre-increment next value.
- Error: if occupancy_o > 2^lg_size_p in any cycle outside reset, err_r <= 1 and holds until reset. This catches a corrupt or unsynchronized r_ptr_gray_i.
- Simultaneous events: a write accepted in the same cycle that r_ptr_gray_i advances is legal. full_o is evaluated against the current-cycle r_ptr_gray_i.
- Full on an equal-address, opposite-wrap condition: ready_o=0 until r_ptr_gray_i changes.
- r_ptr_gray_i is treated as stable within a cycle; the block does not re-synchronize it.

Test Plan:
- Reset, with lg_size_p=2 and r_ptr_gray_i=0:
  - Hold iclk_reset_i=1 for 2 cycles with v_i=1 → w_en_o=0, ready_o=0, w_ptr_gray_o=000, occupancy_o=0, err_o=0.
- Fill from empty, with r_ptr_gray_i=000:
  - Assert v_i for 5 cycles → w_addr_o sequence 0,1,2,3.
  - w_ptr_gray_o sequence 001,011,010,110.
  - full_o=1 after the 4th write; the 5th request is not accepted (w_en_o=0); occupancy_o=4.
- Drain release:
  - From full, set r_ptr_gray_i=001 → full_o=0, ready_o=1, occupancy_o=3.
  - The next write gives w_addr_o=0 and w_ptr_gray_o=111.
- Wrap-around:
  - Keep r_ptr_gray_i one behind the writer while streaming 16 writes → w_ptr_gray_o cycles 001,011,010,110,111,101,100,000 twice.
  - Monitor confirms exactly one bit flips per accepted write; full_o never asserts.
- Error detect:
  - With w_ptr=0, force r_ptr_gray_i=010 (binary 3) → occupancy_o=5, err_o=1 next cycle.
  - err_o stays 1 after r_ptr_gray_i=000; it clears only on iclk_reset_i.
- Mid-stream reset:
  - After 3 writes, pulse iclk_reset_i for 1 cycle with v_i=1 → w_en_o=0 in the reset cycle, w_ptr_gray_o=000 next cycle.
  - The following write uses w_addr_o=0.
